// File: rtl/dff_delay_line_if.sv
// Data-path bundle for dff_delay_line: stage-0 inputs, last-stage outputs, occupancy.
// The parity signals exist only when DFF_DELAY_LINE_PARITY_EN is defined.
interface dff_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [CNT_W-1:0] occ;
    logic             busy;
`ifdef DFF_DELAY_LINE_PARITY_EN
    logic             par_inj;
    logic             par_err;
`endif

    modport master (
        output en, flush, din, din_vld,
`ifdef DFF_DELAY_LINE_PARITY_EN
        output par_inj,
        input  par_err,
`endif
        input  dout, dout_vld, occ, busy
    );

    modport slave (
        input  en, flush, din, din_vld,
`ifdef DFF_DELAY_LINE_PARITY_EN
        input  par_inj,
        output par_err,
`endif
        output dout, dout_vld, occ, busy
    );
endinterface

// File: rtl/dff_delay_line.sv
// Falling-edge delay line of DEPTH valid-qualified stages with stall, flush and occupancy count.
// Define DFF_DELAY_LINE_PARITY_EN to carry a per-stage parity bit with injection and error flag.
module dff_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           clr,
    dff_delay_line_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
`ifdef DFF_DELAY_LINE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_d;
`endif

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        occ_d  = occ_q;
`ifdef DFF_DELAY_LINE_PARITY_EN
        par_d  = par_q;
`endif
        if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
            vld_d = '0;
            occ_d = '0;
`ifdef DFF_DELAY_LINE_PARITY_EN
            par_d = '0;
`endif
        end else if (bus.en) begin
            // Data is captured even when din_vld=0; consumers qualify with the valid bit.
            data_d[0] = bus.din;
            vld_d[0]  = bus.din_vld;
`ifdef DFF_DELAY_LINE_PARITY_EN
            par_d[0]  = (^bus.din) ^ bus.par_inj;
`endif
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
`ifdef DFF_DELAY_LINE_PARITY_EN
                par_d[k]  = par_q[k-1];
`endif
            end
            occ_d = occ_q + CNT_W'(bus.din_vld) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
            occ_q <= '0;
`ifdef DFF_DELAY_LINE_PARITY_EN
            par_q <= '0;
`endif
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            occ_q  <= occ_d;
`ifdef DFF_DELAY_LINE_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    assign bus.dout     = data_q[DEPTH-1];
    assign bus.dout_vld = vld_q[DEPTH-1];
    assign bus.occ      = occ_q;
    assign bus.busy     = |occ_q;
`ifdef DFF_DELAY_LINE_PARITY_EN
    assign bus.par_err  = vld_q[DEPTH-1] & ((^data_q[DEPTH-1]) ^ par_q[DEPTH-1]);
`endif
endmodule

// File: tb/tb_dff_delay_line.sv
// Scoreboard bench for dff_delay_line: each accepted word is queued with the shift count at which
// it must reach dout; a monitor checks outputs after every falling edge.
module tb_dff_delay_line;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef enum int {K_HOLD, K_SHIFT, K_FLUSH} kind_t;
    typedef struct {
        logic [WIDTH-1:0] data;
        bit               par;
        int               due;
    } exp_t;

    logic clk;
    logic clr;
    dff_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    int    shift_cnt = 0;
    kind_t kind = K_HOLD;
    bit    mon_en = 0;
    bit    shown_valid = 0;
    logic [WIDTH-1:0] shown_data = '0;
    bit    shown_par = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One falling edge of stimulus; the model is updated at that edge.
    task automatic step(input bit e, input bit f, input logic [WIDTH-1:0] d, input bit v,
                        input bit pi);
        @(posedge clk);
        bus.en      = e;
        bus.flush   = f;
        bus.din     = d;
        bus.din_vld = v;
`ifdef DFF_DELAY_LINE_PARITY_EN
        bus.par_inj = pi;
`endif
        @(negedge clk);
        if (f) begin
            exp_q.delete();
            kind = K_FLUSH;
        end else if (e) begin
            shift_cnt++;
            if (v) exp_q.push_back('{data: d, par: pi, due: shift_cnt + DEPTH - 1});
            kind = K_SHIFT;
        end else begin
            kind = K_HOLD;
        end
    endtask

    // Pulse clr between falling edges and check the clear takes effect before the next edge.
    task automatic clr_pulse();
        @(posedge clk);
        bus.en      = 1'b0;
        bus.flush   = 1'b0;
        bus.din_vld = 1'b0;
        #1 clr = 1'b1;
        #1;
        check("clr_dout", bus.dout, 0);
        check("clr_dout_vld", bus.dout_vld, 0);
        check("clr_occ", bus.occ, 0);
        check("clr_busy", bus.busy, 0);
        exp_q.delete();
        shown_valid = 0;
        #1 clr = 1'b0;
        @(negedge clk);
        kind = K_HOLD;
    endtask

    initial begin : monitor
        int occ_exp;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (kind == K_FLUSH) begin
                    shown_valid = 0;
                    check("flush_dout", bus.dout, 0);
                end else if (kind == K_SHIFT) begin
                    if (exp_q.size() > 0 && exp_q[0].due == shift_cnt) begin
                        e = exp_q.pop_front();
                        shown_valid = 1;
                        shown_data  = e.data;
                        shown_par   = e.par;
                    end else begin
                        shown_valid = 0;
                    end
                end
                check("dout_vld", bus.dout_vld, shown_valid);
                if (shown_valid) check("dout", bus.dout, shown_data);
                occ_exp = exp_q.size() + int'(shown_valid);
                check("occ", bus.occ, occ_exp);
                check("busy", bus.busy, occ_exp != 0);
`ifdef DFF_DELAY_LINE_PARITY_EN
                check("par_err", bus.par_err, shown_valid & shown_par);
`endif
            end
        end
    end

    initial begin : stimulus
        clr         = 1'b1;
        bus.en      = 1'b0;
        bus.flush   = 1'b0;
        bus.din     = '0;
        bus.din_vld = 1'b0;
`ifdef DFF_DELAY_LINE_PARITY_EN
        bus.par_inj = 1'b0;
`endif
        #2;
        check("rst_dout", bus.dout, 0);
        check("rst_dout_vld", bus.dout_vld, 0);
        check("rst_occ", bus.occ, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1 clr = 1'b0;
        mon_en = 1;

        // Single word latency
        step(1, 0, 8'hA5, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 8'(i), 0, 0);

        // Stall after the second word
        step(1, 0, 8'h01, 1, 0);
        step(1, 0, 8'h02, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'hEE, 1, 0);
        step(1, 0, 8'h03, 1, 0);
        step(1, 0, 8'h04, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 0, 0);

        // Steady state full, then flush beats en
        for (int i = 0; i < 10; i++) step(1, 0, 8'h10 + 8'(i), 1, 0);
        step(1, 1, 8'h77, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 0);

        // Async clear of a full pipeline, then a fresh word
        for (int i = 0; i < 5; i++) step(1, 0, 8'h20 + 8'(i), 1, 0);
        clr_pulse();
        step(1, 0, 8'h3C, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 0);

`ifdef DFF_DELAY_LINE_PARITY_EN
        step(1, 0, 8'h0F, 1, 1);
        step(1, 0, 8'h0F, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0, 0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                clr_pulse();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                     8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 8'h00, 0, 0);
        check("drained", exp_q.size(), 0);

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dff_delay_line.md
Name: dff_delay_line

Overview:
- Parametrised falling-edge register pipeline, the successor to the single negedge D flip-flop with asynchronous clear.
- Holds DEPTH stages of WIDTH-bit data, each stage with its own valid bit.
- Supports stall (en), synchronous flush and a registered occupancy count.
- Used to delay and retime data buses by a fixed number of falling clock edges, clocked from the shared clock generator.

Parameters:
WIDTH, 8, data bits per stage; legal range 1 or more.
DEPTH, 4, number of stages, equal to the latency in falling edges; legal range 1 or more.
CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, do not override.

Ports:
clk  input  1  clock; all state updates on the falling edge.
clr  input  1  reset clr, asynchronous, active-high; clears all state.
en  input  1  advance enable; 1 shifts the pipeline by one stage, 0 holds it.
flush  input  1  synchronous clear of all stages, sampled on the falling edge.
din  input  WIDTH  data into stage 0.
din_vld  input  1  valid qualifier for din.
dout  output  WIDTH  data of stage DEPTH-1.
dout_vld  output  1  valid bit of stage DEPTH-1.
occ  output  CNT_W  number of valid stages, registered.
busy  output  1  1 when occ != 0, combinational from occ.

Behaviour:
- Reset:
  - clr=1 immediately, without waiting for a clock edge, sets all stage data to 0, all valid bits to 0 and occ to 0. This gives dout=0, dout_vld=0, occ=0, busy=0.
  - State is held at these values while clr=1. Normal operation resumes at the first falling edge after clr deasserts.
  - clr asserted mid-transfer discards all in-flight data; no partial state survives.
- Priority at each falling edge: clr > flush > en.
- flush=1:
  - All stage data goes to 0, all valid bits to 0, occ to 0.
  - din is discarded regardless of en or din_vld.
- en=1, flush=0:
  - Stage 0 takes {din_vld, din}; stage k takes stage k-1 for k=1..DEPTH-1.
  - When din_vld=0, stage 0 data still captures din; downstream logic must qualify data with the valid bit.
  - occ_next = occ + din_vld - (valid bit of stage DEPTH-1).
  - Simultaneous entry and exit leaves occ unchanged. occ never exceeds DEPTH and never underflows.
- en=0, flush=0: all stages and occ hold.
- Latency: a word presented with en held at 1 appears on dout/dout_vld after exactly DEPTH falling edges. Each cycle with en=0 adds one edge.
- DEPTH=1: a single stage; dout follows din one falling edge later; occ is 0 or 1.
- Outputs are driven directly from stage registers, with no combinational path from din to dout.
- Inputs are sampled only at falling edges; changes between edges have no effect, except clr.

Optional Feature:
Macro: DFF_DELAY_LINE_PARITY_EN
- Defined:
  - Each stage carries one extra parity bit, computed at stage 0 as ^din XOR par_inj.
  - Adds input par_inj (1 bit) and output par_err (1 bit).
  - par_err = dout_vld AND (^dout XOR stage parity), combinational from the last stage.
  - The parity bit clears with clr and flush like the data bits.
- Undefined: no parity storage, and neither par_inj nor par_err exists on the port list. Behaviour is otherwise identical.

Test Plan:
1. Latency: WIDTH=8, DEPTH=4, en=1; drive din=8'hA5 with din_vld=1 for one edge, then din_vld=0 -> dout=8'hA5 and dout_vld=1 after the 4th falling edge, for exactly one edge; occ goes 1,1,1,1,0.
2. Stall: stream 8'h01..8'h04 with din_vld=1, hold en=0 for 3 edges after the 2nd word -> dout sequence unchanged, delayed by 3 edges; occ frozen at 2 during the stall.
3. Full/steady state: continuous din_vld=1 for 10 edges -> occ saturates at 4 and stays 4; busy=1; dout lags din by 4 edges.
4. Flush versus en: pipeline full with occ=4; assert flush=1 and en=1 with din_vld=1 for one edge -> next edge gives occ=0, dout=0, dout_vld=0; din is discarded.
5. Asynchronous clear: pipeline full; pulse clr high between falling edges -> dout=0, dout_vld=0, occ=0 before the next edge; after clr deasserts, a new word emerges after 4 edges.
6. Parity (macro defined): din=8'h0F, par_inj=1 -> par_err=1 coincident with dout_vld after 4 edges. With par_inj=0 -> par_err stays 0.
